ks_memory: RTL

//   Memory-side responder for the K&S core's 5-bit ram_addr / 16-bit data bus:
//   32x16 word RAM; answers the data path's read and write requests.

---
 rtl/ks_memory.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ks_memory.sv
// ---------------------------------------------------------------------------
// ks_memory
//   Memory-side responder for the K&S core. Holds a 32x16 word RAM that the
//   data path reads and writes through ram_addr / wr_data / rd_data, plus a
//   valid/ready program-loader port that fills the RAM from word 0 upward
//   while the core is held off via core_hold.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst_n             asynchronous active-low reset (zeroes RAM and outputs)
//   ram_addr          core word address
//   ram_write_enable  core write strobe, honoured only when no load is active
//   wr_data           core write data
//   rd_data           registered read data, 1-cycle latency, write-first
//   load_start        1-cycle pulse that starts a program load from IDLE
//   load_valid        loader word valid
//   load_data         loader word
//   load_last         marks the final loader word (qualified by load_valid)
//   load_ready        loader may transfer this cycle
//   load_done         1-cycle pulse when a load has finished
//   load_count        words written by the current or most recent load
//   core_hold         high while a load is in progress or finishing
// ---------------------------------------------------------------------------
module ks_memory #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic              ram_write_enable,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count,
   output logic              core_hold
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Pointer value of the last word the RAM can hold; a transfer here ends the load.
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

   state_t              state;
   state_t              state_next;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                transfer;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   // A loader word moves only while loading; load_ready is high for the whole LOAD state.
   assign transfer = (state == LOAD) && load_valid;

   // State register for the load sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a load ends on a word flagged last or on the word that
   // fills the final RAM location, so the pointer can never wrap.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (load_start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (transfer && (load_last || (load_count == LAST_PTR))) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake and hold outputs are pure functions of the state.
   always_comb begin
      load_ready = 1'b0;
      load_done  = 1'b0;
      core_hold  = 1'b0;
      case (state)
         LOAD: begin
            load_ready = 1'b1;
            core_hold  = 1'b1;
         end
         DONE: begin
            load_done = 1'b1;
            core_hold = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Single RAM write port: the core owns it in IDLE, the loader owns it in LOAD,
   // and nobody writes in DONE.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ram_addr;
      mem_wdata = wr_data;
      case (state)
         IDLE: begin
            mem_we = ram_write_enable;
         end
         LOAD: begin
            if (transfer) begin
               mem_we    = 1'b1;
               mem_waddr = load_count[ADDR_W-1:0];
               mem_wdata = load_data;
            end
         end
         default: begin
         end
      endcase
   end

   // RAM array, read register and load counter. load_count doubles as the
   // loader write pointer since both start at zero and step together.
   // The read path is write-first: a write landing on the address being read
   // returns the new word on the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_data    <= '0;
         load_count <= '0;
      end else begin
         if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
         end
         if (mem_we && (mem_waddr == ram_addr)) begin
            rd_data <= mem_wdata;
         end else begin
            rd_data <= mem[ram_addr];
         end
         if ((state == IDLE) && load_start) begin
            load_count <= '0;
         end else if (transfer) begin
            load_count <= load_count + 1'b1;
         end
      end
   end

endmodule
